// File: rtl/serial_rx_ctrl_if.sv
// Bundles the rx line, enable and word handshake of the serial receive controller.
// master = receiver side (drives the word and flags), slave = line driver/consumer side.
interface serial_rx_ctrl_if #(
    parameter int DATA_BITS = 8
);
    logic                 rx_in;
    logic                 rx_en;
    logic [DATA_BITS-1:0] data_out;
    logic                 data_valid;
    logic                 data_ready;
    logic                 bit_strobe;
    logic                 frame_err;
    logic                 overrun;
    logic                 busy;

    modport master (
        input  rx_in, rx_en, data_ready,
        output data_out, data_valid, bit_strobe, frame_err, overrun, busy
    );

    modport slave (
        output rx_in, rx_en, data_ready,
        input  data_out, data_valid, bit_strobe, frame_err, overrun, busy
    );
endinterface

// File: rtl/serial_rx_ctrl.sv
// Serial receiver: 2-flop sync, mid-bit LSB-first sampling; word valid CLKS_PER_BIT/2+(DATA_BITS+1)*CLKS_PER_BIT+1 cycles after start seen on rx_sync.
// The line cannot be stalled: a word completing while the previous one is unaccepted is dropped and flagged as overrun.
module serial_rx_ctrl #(
    parameter int CLKS_PER_BIT = 16,
    parameter int DATA_BITS    = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    serial_rx_ctrl_if.master  bus
);
    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam int IW = $clog2(DATA_BITS + 1);
    localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
    localparam logic [IW-1:0] IDX_LAST  = IW'(DATA_BITS - 1);

    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_STOP, S_BREAK} state_t;

    state_t               state, state_nxt;
    logic                 rx_meta, rx_sync;
    logic [CW-1:0]        baud_cnt, baud_nxt;
    logic [IW-1:0]        bit_idx, idx_nxt;
    logic [DATA_BITS-1:0] shift_reg, shift_nxt;
    logic [DATA_BITS-1:0] data_reg;
    logic                 valid_reg, ferr_reg, ovr_reg;
    logic                 strobe, word_done, stop_bad;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_meta <= 1'b1;
            rx_sync <= 1'b1;
        end else begin
            rx_meta <= bus.rx_in;
            rx_sync <= rx_meta;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            baud_cnt  <= '0;
            bit_idx   <= '0;
            shift_reg <= '0;
        end else begin
            state     <= state_nxt;
            baud_cnt  <= baud_nxt;
            bit_idx   <= idx_nxt;
            shift_reg <= shift_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        baud_nxt  = baud_cnt;
        idx_nxt   = bit_idx;
        shift_nxt = shift_reg;
        strobe    = 1'b0;
        word_done = 1'b0;
        stop_bad  = 1'b0;
        case (state)
            S_IDLE: begin
                if (bus.rx_en && !rx_sync) begin
                    state_nxt = S_START;
                    baud_nxt  = '0;
                end
            end
            S_START: begin
                // A start bit that is high again at mid-bit is treated as line noise.
                if (baud_cnt == HALF_LAST) begin
                    baud_nxt  = '0;
                    idx_nxt   = '0;
                    state_nxt = rx_sync ? S_IDLE : S_DATA;
                end else begin
                    baud_nxt = baud_cnt + 1'b1;
                end
            end
            S_DATA: begin
                if (baud_cnt == BIT_LAST) begin
                    baud_nxt                 = '0;
                    strobe                   = 1'b1;
                    shift_nxt                = shift_reg >> 1;
                    shift_nxt[DATA_BITS-1]   = rx_sync;
                    idx_nxt                  = bit_idx + 1'b1;
                    if (bit_idx == IDX_LAST) begin
                        state_nxt = S_STOP;
                    end
                end else begin
                    baud_nxt = baud_cnt + 1'b1;
                end
            end
            S_STOP: begin
                if (baud_cnt == BIT_LAST) begin
                    baud_nxt = '0;
                    if (rx_sync) begin
                        word_done = 1'b1;
                        state_nxt = S_IDLE;
                    end else begin
                        stop_bad  = 1'b1;
                        state_nxt = S_BREAK;
                    end
                end else begin
                    baud_nxt = baud_cnt + 1'b1;
                end
            end
            S_BREAK: begin
                if (rx_sync) begin
                    state_nxt = S_IDLE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // The handshake decision is taken on the stop-sample cycle so the word shows up one cycle later.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_reg  <= '0;
            valid_reg <= 1'b0;
            ferr_reg  <= 1'b0;
            ovr_reg   <= 1'b0;
        end else begin
            ferr_reg <= stop_bad;
            ovr_reg  <= 1'b0;
            if (word_done) begin
                if (!valid_reg || bus.data_ready) begin
                    data_reg  <= shift_reg;
                    valid_reg <= 1'b1;
                end else begin
                    ovr_reg <= 1'b1;
                end
            end else if (valid_reg && bus.data_ready) begin
                valid_reg <= 1'b0;
            end
        end
    end

    assign bus.data_out   = data_reg;
    assign bus.data_valid = valid_reg;
    assign bus.bit_strobe = strobe;
    assign bus.frame_err  = ferr_reg;
    assign bus.overrun    = ovr_reg;
    assign bus.busy       = (state != S_IDLE);
endmodule
